// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage request and hazard-response bundle for hazard_scoreboard
// The master drives the decoded ID fields; the slave returns stall/flush/busy/stall count.
interface hazard_scoreboard_if #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int LW   = 2,
  parameter int CW   = 16
);
  logic            id_valid;
  logic [AW-1:0]   id_rs;
  logic [AW-1:0]   id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic            id_reg_write;
  logic [AW-1:0]   id_dst;
  logic [LW-1:0]   id_lat;
  logic [LW-1:0]   id_rdy;
  logic            id_branch_taken;
  logic            stall;
  logic            flush_if;
  logic [NREG-1:0] busy;
  logic [CW-1:0]   stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_reg_write,
           id_dst, id_lat, id_rdy, id_branch_taken,
    input  stall, flush_if, busy, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_reg_write,
           id_dst, id_lat, id_rdy, id_branch_taken,
    output stall, flush_if, busy, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - countdown scoreboard: RAW/WAW stall, taken-branch IF flush, stall counter
// Optional HAZARD_FWD_EN: source checks use per-register forwarding-ready counters.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int LW       = 2,
  parameter int CW       = 16,
  parameter int ZERO_REG = 1
) (
  input logic           clk_i,
  input logic           rst_n_i,
  hazard_scoreboard_if.slave bus
);
  localparam logic [CW-1:0] SC_MAX = '1;

  logic [LW-1:0] wb_cnt_q [NREG];
  logic [LW-1:0] wb_cnt_d [NREG];
`ifdef HAZARD_FWD_EN
  logic [LW-1:0] rdy_cnt_q [NREG];
  logic [LW-1:0] rdy_cnt_d [NREG];
`else
  logic          unused_rdy;
  assign unused_rdy = ^bus.id_rdy;
`endif
  logic [CW-1:0] stall_cycles_q, stall_cycles_d;

  logic [LW-1:0] rs_cnt, rt_cnt, dst_wb;
  logic          rs_hz, rt_hz, waw_hz, stall, issue, track;

  // Out-of-range indices and (optionally) r0 never participate in tracking.
  function automatic logic idx_ok(input logic [AW-1:0] idx);
    return (int'(idx) < NREG) && !((ZERO_REG != 0) && (idx == '0));
  endfunction

  always_comb begin
    rs_cnt = '0;
    rt_cnt = '0;
    dst_wb = '0;
    for (int r = 0; r < NREG; r++) begin
`ifdef HAZARD_FWD_EN
      if (bus.id_rs == AW'(r)) rs_cnt = rdy_cnt_q[r];
      if (bus.id_rt == AW'(r)) rt_cnt = rdy_cnt_q[r];
`else
      if (bus.id_rs == AW'(r)) rs_cnt = wb_cnt_q[r];
      if (bus.id_rt == AW'(r)) rt_cnt = wb_cnt_q[r];
`endif
      if (bus.id_dst == AW'(r)) dst_wb = wb_cnt_q[r];
    end
  end

  assign rs_hz  = bus.id_use_rs & idx_ok(bus.id_rs) & (rs_cnt != '0);
  assign rt_hz  = bus.id_use_rt & idx_ok(bus.id_rt) & (rt_cnt != '0);
  // A younger write must not retire ahead of an older, longer one to the same register.
  assign waw_hz = bus.id_reg_write & idx_ok(bus.id_dst) & (dst_wb > bus.id_lat);

  assign stall  = rst_n_i & bus.id_valid & (rs_hz | rt_hz | waw_hz);
  assign issue  = bus.id_valid & ~stall;
  assign track  = issue & bus.id_reg_write & idx_ok(bus.id_dst);

  assign bus.stall        = stall;
  assign bus.flush_if     = rst_n_i & bus.id_valid & bus.id_branch_taken & ~stall;
  assign bus.stall_cycles = stall_cycles_q;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      bus.busy[r] = (wb_cnt_q[r] != '0);
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wb_cnt_d[r] = (wb_cnt_q[r] != '0) ? wb_cnt_q[r] - LW'(1) : '0;
`ifdef HAZARD_FWD_EN
      rdy_cnt_d[r] = (rdy_cnt_q[r] != '0) ? rdy_cnt_q[r] - LW'(1) : '0;
`endif
      if (track && (bus.id_dst == AW'(r))) begin
        wb_cnt_d[r] = bus.id_lat;
`ifdef HAZARD_FWD_EN
        rdy_cnt_d[r] = bus.id_rdy;
`endif
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != SC_MAX)) stall_cycles_d = stall_cycles_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < NREG; r++) begin
        wb_cnt_q[r] <= '0;
`ifdef HAZARD_FWD_EN
        rdy_cnt_q[r] <= '0;
`endif
      end
      stall_cycles_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        wb_cnt_q[r] <= wb_cnt_d[r];
`ifdef HAZARD_FWD_EN
        rdy_cnt_q[r] <= rdy_cnt_d[r];
`endif
      end
      stall_cycles_q <= stall_cycles_d;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed + randomized scoreboard bench for hazard_scoreboard
// Reference model tracks absolute ready times per register; a monitor pops expectations each cycle.
module tb_hazard_scoreboard;
  localparam int NREG = 24, AW = 5, LW = 2, CW = 6, ZERO_REG = 1;
  localparam int SC_MAX = (1 << CW) - 1;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREG(NREG), .AW(AW), .LW(LW), .CW(CW)) bus ();

  hazard_scoreboard #(.NREG(NREG), .AW(AW), .LW(LW), .CW(CW), .ZERO_REG(ZERO_REG)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  typedef struct {
    int              cyc;
    logic            stall;
    logic            flush;
    logic [NREG-1:0] busy;
    logic [CW-1:0]   sc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  int now_e = 0;
  int wb_ready [NREG];
  int rd_ready [NREG];
  int sc_m = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want, input int c);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, c, got, want);
    end
  endtask

  function automatic bit idx_ok(input int idx);
    return (idx < NREG) && !((ZERO_REG != 0) && (idx == 0));
  endfunction

  function automatic int rem(input int ready);
    return (ready > now_e) ? ready - now_e : 0;
  endfunction

  function automatic int src_rem(input int idx);
    if (!idx_ok(idx)) return 0;
    return FWD ? rem(rd_ready[idx]) : rem(wb_ready[idx]);
  endfunction

  function automatic int wb_rem(input int idx);
    if (!idx_ok(idx)) return 0;
    return rem(wb_ready[idx]);
  endfunction

  task automatic clear_model();
    for (int r = 0; r < NREG; r++) begin
      wb_ready[r] = 0;
      rd_ready[r] = 0;
    end
    now_e = 0;
    sc_m  = 0;
  endtask

  task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit rw, input int dst, input int lat, input int rdy, input bit br);
    bus.id_valid        = v;
    bus.id_rs           = AW'(rs);
    bus.id_rt           = AW'(rt);
    bus.id_use_rs       = urs;
    bus.id_use_rt       = urt;
    bus.id_reg_write    = rw;
    bus.id_dst          = AW'(dst);
    bus.id_lat          = LW'(lat);
    bus.id_rdy          = LW'(rdy);
    bus.id_branch_taken = br;
  endtask

  // One ID cycle: predict the response, queue it, then advance the model past the next edge.
  task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                      input bit rw, input int dst, input int lat, input int rdy, input bit br,
                      output bit st);
    exp_t e;
    bit   hz;
    @(negedge clk);
    cyc++;
    drive(v, rs, rt, urs, urt, rw, dst, lat, rdy, br);
    hz = (urs && src_rem(rs) > 0) || (urt && src_rem(rt) > 0) || (rw && wb_rem(dst) > lat);
    st = v && hz;
    e.cyc   = cyc;
    e.stall = st;
    e.flush = v && br && !st;
    e.sc    = CW'(sc_m);
    for (int r = 0; r < NREG; r++) e.busy[r] = (rem(wb_ready[r]) > 0);
    #1 exp_q.push_back(e);
    if (v && !st && rw && idx_ok(dst)) begin
      wb_ready[dst] = now_e + 1 + lat;
      rd_ready[dst] = now_e + 1 + rdy;
    end
    if (st && sc_m < SC_MAX) sc_m++;
    now_e++;
  endtask

  task automatic issue(input int rs, input int rt, input bit urs, input bit urt, input bit rw,
                       input int dst, input int lat, input int rdy, input bit br, output int nstall);
    bit st;
    nstall = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, rs, rt, urs, urt, rw, dst, lat, rdy, br, st);
      if (!st) return;
      nstall++;
    end
    checks++;
    errors++;
    $display("FAIL issue_bound @cyc %0d: still stalled after %0d cycles", cyc, nstall);
  endtask

  task automatic bubble();
    bit st;
    step(1'b0, $urandom_range(0, 31), $urandom_range(0, 31), 1'b1, 1'b1, 1'b1,
         $urandom_range(0, 31), 3, 3, $urandom_range(0, 1), st);
  endtask

  // Assert reset between edges with a hazard-looking, branch-taken instruction applied.
  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    cyc++;
    rst_n = 1'b0;
    drive(1'b1, 5, 5, 1'b1, 1'b1, 1'b1, 5, 0, 0, 1'b1);
    e.cyc = cyc; e.stall = 1'b0; e.flush = 1'b0; e.busy = '0; e.sc = '0;
    #1 exp_q.push_back(e);
    clear_model();
    repeat (2) @(negedge clk);
    cyc += 2;
    bus.id_valid = 1'b0;
    rst_n = 1'b1;
    now_e++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall",        32'(bus.stall),        32'(e.stall), e.cyc);
        check("flush_if",     32'(bus.flush_if),     32'(e.flush), e.cyc);
        check("busy",         32'(bus.busy),         32'(e.busy),  e.cyc);
        check("stall_cycles", 32'(bus.stall_cycles), 32'(e.sc),    e.cyc);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int lat;
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    clear_model();
    do_reset();

    // RAW without forwarding benefit: add $5 lat 2, consumer via Rs stalls exactly 2 cycles
    issue(1, 2, 1'b1, 1'b1, 1'b1, 5, 2, 2, 1'b0, n);
    issue(5, 3, 1'b1, 1'b1, 1'b1, 6, 1, 1, 1'b0, n);
    check("raw_gap", 32'(n), 32'd2, cyc);

    // Reset mid-run while wb_cnt[5] == 2
    issue(1, 2, 1'b1, 1'b1, 1'b1, 5, 2, 2, 1'b0, n);
    do_reset();

    // Load-use through Rt
    issue(1, 2, 1'b1, 1'b0, 1'b1, 8, 2, 1, 1'b0, n);
    issue(3, 8, 1'b1, 1'b1, 1'b1, 11, 1, 0, 1'b0, n);
    check("load_use", 32'(n), FWD ? 32'd1 : 32'd2, cyc);
    issue(1, 2, 1'b1, 1'b1, 1'b1, 12, 1, 0, 1'b0, n);
    issue(12, 4, 1'b1, 1'b1, 1'b1, 13, 1, 0, 1'b0, n);
    check("alu_use", 32'(n), FWD ? 32'd0 : 32'd1, cyc);

    // r0, unused source and out-of-range indices never hazard
    issue(1, 2, 1'b0, 1'b0, 1'b1, 0, 3, 3, 1'b0, n);
    issue(0, 0, 1'b1, 1'b1, 1'b1, 14, 0, 0, 1'b0, n);
    check("r0_src", 32'(n), 32'd0, cyc);
    issue(1, 2, 1'b0, 1'b0, 1'b1, 7, 3, 3, 1'b0, n);
    issue(1, 7, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, n);
    check("unused_rt", 32'(n), 32'd0, cyc);
    issue(1, 2, 1'b0, 1'b0, 1'b1, 28, 3, 3, 1'b0, n);
    issue(28, 30, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, n);
    check("out_of_range", 32'(n), 32'd0, cyc);

    // Taken branch waiting on Rs: stall without flush, then flush on issue
    issue(1, 2, 1'b0, 1'b0, 1'b1, 6, 1, 1, 1'b0, n);
    issue(6, 0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1, n);
    check("branch_wait", 32'(n), 32'd1, cyc);

    // WAW: mult $9 lat 3 then addi $9 lat 1 waits until wb_cnt[9] <= 1
    issue(1, 2, 1'b1, 1'b1, 1'b1, 9, 3, 3, 1'b0, n);
    issue(0, 0, 1'b0, 1'b0, 1'b1, 9, 1, 1, 1'b0, n);
    check("waw_gap", 32'(n), 32'd2, cyc);

    // Drive the stall counter well past saturation
    do_reset();
    for (int i = 0; i < 25; i++) begin
      issue(1, 2, 1'b0, 1'b0, 1'b1, 10, 3, 3, 1'b0, n);
      issue(10, 10, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, n);
    end
    check("sc_saturated", 32'(sc_m), 32'(SC_MAX), cyc);

    // Randomized instruction stream with bubbles
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 15) begin
        bubble();
      end else begin
        lat = $urandom_range(0, 3);
        issue($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 31),
              lat, $urandom_range(0, lat), $urandom_range(0, 4) == 0, n);
      end
    end

    repeat (3) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0, cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised scoreboard-based hazard unit for the 5-stage pipeline, with branches resolved in Decode. Per-register countdown counters track in-flight destination writes. The unit stalls the instruction in ID while any source it reads is still unavailable, or while a write-after-write ordering would be violated. It supports variable result latency (ALU, load, multi-cycle ops), generates the IF flush for taken branches, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- NREG, 32: number of architectural registers.
- AW, 5: register index width; must satisfy 2^AW >= NREG.
- LW, 2: latency field width; MAX_LAT = 2^LW-1.
- CW, 16: stall-cycle counter width.
- ZERO_REG, 1: when 1, register 0 is never tracked or busy.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- ID_Valid  in  1  a valid instruction occupies ID.
- ID_Rs, ID_Rt  in  AW each  source register indices.
- ID_UseRs, ID_UseRt  in  1 each  the corresponding source is actually read.
- ID_RegWrite  in  1  instruction writes a register.
- ID_Dst  in  AW  destination index, already RegDst-muxed.
- ID_Lat  in  LW  cycles after issue during which the result is not readable from the register file; 0 means no tracking.
- ID_Rdy  in  LW  cycles after issue until the result is forwardable; must be <= ID_Lat. Only used with forwarding.
- ID_BranchTaken  in  1  branch/jump resolved taken in ID.
- Stall  out  1  hold PC and IF/ID, insert bubble into ID/EX. Combinational.
- FlushIF  out  1  squash the IF/ID register. Combinational.
- Busy  out  NREG  bit r = (wb_cnt[r] != 0).
- StallCycles  out  CW  saturating count of stalled cycles.

## Operation
- State: wb_cnt[NREG] and rdy_cnt[NREG], each LW bits wide; plus StallCycles.
- Issue = ID_Valid & ~Stall.
- Track = Issue & ID_RegWrite & (ID_Dst != 0 or ZERO_REG == 0).
- Per-cycle counter update, per register r:
  - if Track and r == ID_Dst: wb_cnt[r] <= ID_Lat, rdy_cnt[r] <= ID_Rdy;
  - else any nonzero counter decrements by 1;
  - counters at 0 stay at 0.
- The load overrides the decrement of the same register in the same cycle.
- Source hazard: for each source with ID_UseXx=1 and index X, hazard if the selected counter[X] != 0. The selected counter is wb_cnt, or rdy_cnt under forwarding.
- Rs == Rt is checked once; no double counting.
- WAW hazard: ID_RegWrite=1 and wb_cnt[ID_Dst] > ID_Lat. A younger short-latency write must not complete before an older long one.
- Stall = ID_Valid & (source hazard or WAW hazard).
- Stall is 0 whenever ID_Valid=0, regardless of counters.
- FlushIF = ID_Valid & ID_BranchTaken & ~Stall. A branch waiting on its operands does not flush until it issues.
- With ZERO_REG=1, index 0 is ignored in all hazard checks and its counters stay 0.
- Indices >= NREG never hazard and are never tracked.
- StallCycles increments on every cycle with Stall=1 and holds at 2^CW-1.

## Timing
- Reset (Rst_n=0, asynchronous): all wb_cnt, rdy_cnt and StallCycles clear to 0 immediately. Therefore Busy=0, and Stall=0 and FlushIF=0 for any input.
- Reset deasserted mid-operation loses all in-flight tracking; the pipeline is flushed by the same reset.
- Stall and FlushIF are combinational from ID inputs and current counters, with no added latency.
- Counters and StallCycles change only on rising Clk.
- Dependent-instruction gap: a producer issued at edge t with ID_Lat=L stalls an immediately following consumer for exactly L cycles. The consumer issues at edge t+L+1.
- Back-to-back writes to the same register: the second load replaces the first. The WAW rule guarantees the new wb_cnt >= old wb_cnt-1.

## Configuration
- HAZARD_FWD_EN defined:
  - the source check uses rdy_cnt;
  - ID_Rdy is loaded on Track;
  - consumers stall only until the producer's result reaches a forwarding point.
- HAZARD_FWD_EN undefined:
  - the rdy_cnt array is not instantiated;
  - ID_Rdy is ignored;
  - the source check uses wb_cnt (full interlock to register-file writeback).
- In both builds the WAW check uses wb_cnt.

## Test plan
- Reset: assert Rst_n=0 mid-run with wb_cnt[5]=2 -> Busy=0, StallCycles=0 and Stall=0 immediately, without waiting for a clock edge.
- RAW, no forwarding: issue `add $5` with ID_Lat=2, then a consumer reading $5 via Rs -> Stall=1 for exactly 2 cycles; the consumer issues on the 3rd cycle; StallCycles=2.
- Load-use, HAZARD_FWD_EN: issue `lw $8` with ID_Lat=2, ID_Rdy=1, then `add` reading $8 via Rt -> exactly 1 stall cycle. An ALU producer with ID_Rdy=0 causes 0 stalls.
- Register 0 and unused sources: producer writes $0; consumer reads $0; consumer with ID_UseRt=0 has ID_Rt equal to a busy register -> Stall=0 in all cases.
- Branch: `beq` with ID_BranchTaken=1 and Rs busy (wb_cnt=1) -> Stall=1, FlushIF=0 in that cycle; next cycle Stall=0, FlushIF=1.
- WAW and saturation: `mult $9` with ID_Lat=3, then `addi $9` with ID_Lat=1 -> stalls until wb_cnt[9]<=1. Separately, force 2^CW+5 stall cycles -> StallCycles holds at 2^CW-1.
